// File: rtl/bank_tracker_pkg.sv
// Shared types and widths for the per-bank request tracker.
package bank_tracker_pkg;

    localparam int CYCLE_W    = 64;
    localparam int ADDR_W_DEF = 32;
    localparam int ID_W_DEF   = 32;

    typedef struct packed {
        logic [ID_W_DEF-1:0]   id;
        logic [ADDR_W_DEF-1:0] addr;
        logic                  is_write;
        logic [CYCLE_W-1:0]    issue_cycle;
    } tracker_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [ID_W_DEF-1:0]   request_id;
        logic [ADDR_W_DEF-1:0] addr;
        logic                  rd_en;
        logic                  wr_en;
        logic [CYCLE_W-1:0]    cycle;
        logic [CYCLE_W-1:0]    latency;
    } tracker_stat_t;

endpackage

// File: rtl/tracker_fifo.sv
// In-order circular buffer of outstanding requests; wrap-bit pointers give
// full/empty without a separate occupancy register.
module tracker_fifo
    import bank_tracker_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = tracker_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t      mem_q [DEPTH];
    logic [PW:0] wr_ptr_q;
    logic [PW:0] wr_ptr_d;
    logic [PW:0] rd_ptr_q;
    logic [PW:0] rd_ptr_d;
    logic        push_ok_s;
    logic        pop_ok_s;

    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign count     = wr_ptr_q - rd_ptr_q;
    assign head      = mem_q[rd_ptr_q[PW-1:0]];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/bank_request_tracker.sv
// Tags requests for one (rank, bank) scheduler, tracks them in order and
// emits a registered statistics record per completion.
module bank_request_tracker
    import bank_tracker_pkg::*;
#(
    parameter int RANK   = 0,
    parameter int BANK   = 0,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic                   req_is_write,
    input  logic                   resp_valid,
    output logic [CYCLE_W-1:0]     global_cycle,
    output logic                   stat_valid,
    output logic [ID_W-1:0]        stat_request_id,
    output logic [ADDR_W-1:0]      stat_addr,
    output logic                   stat_rd_en,
    output logic                   stat_wr_en,
    output logic [CYCLE_W-1:0]     stat_cycle,
    output logic [CYCLE_W-1:0]     stat_latency,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic [31:0]            total_reads,
    output logic [31:0]            total_writes,
    output logic [CYCLE_W-1:0]     max_latency,
    output logic                   err_underflow
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RANK < 0 || BANK < 0) begin : g_bad_param
        $error("bank_request_tracker: DEPTH must be a power of two >= 2, RANK/BANK non-negative");
    end

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic               is_write;
        logic [CYCLE_W-1:0] issue_cycle;
    } entry_t;

    typedef struct packed {
        logic               valid;
        logic [ID_W-1:0]    request_id;
        logic [ADDR_W-1:0]  addr;
        logic               rd_en;
        logic               wr_en;
        logic [CYCLE_W-1:0] cycle;
        logic [CYCLE_W-1:0] latency;
    } stat_t;

    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [ID_W-1:0]    id_q, id_d;
    stat_t              stat_q, stat_d;
    logic [31:0]        reads_q, reads_d;
    logic [31:0]        writes_q, writes_d;
    logic [CYCLE_W-1:0] max_q, max_d;
    logic               err_q, err_d;

    entry_t             push_entry_s;
    entry_t             head_s;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic [CYCLE_W-1:0] latency_s;

    // Pop decisions use current occupancy, so a push into an empty table is never popped the same cycle.
    assign req_ready = !full_s;
    assign push_s    = req_valid && !full_s;
    assign pop_s     = resp_valid && !empty_s;
    assign latency_s = cycle_q - head_s.issue_cycle;

    tracker_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (outstanding)
    );

    // Next-state for counters, stat record and sticky error.
    always_comb begin
        push_entry_s.id          = id_q;
        push_entry_s.addr        = req_addr;
        push_entry_s.is_write    = req_is_write;
        push_entry_s.issue_cycle = cycle_q;
        cycle_d  = cycle_q + 64'd1;
        err_d    = err_q | (resp_valid & empty_s);
        stat_d   = stat_q;
        reads_d  = reads_q;
        writes_d = writes_q;
        max_d    = max_q;
        if (push_s) begin
            id_d = id_q + ID_W'(1);
        end else begin
            id_d = id_q;
        end
        if (pop_s) begin
            stat_d.valid      = 1'b1;
            stat_d.request_id = head_s.id;
            stat_d.addr       = head_s.addr;
            stat_d.rd_en      = !head_s.is_write;
            stat_d.wr_en      = head_s.is_write;
            stat_d.cycle      = cycle_q;
            stat_d.latency    = latency_s;
            if (head_s.is_write) begin
                writes_d = writes_q + 32'd1;
            end else begin
                reads_d = reads_q + 32'd1;
            end
            if (latency_s > max_q) begin
                max_d = latency_s;
            end else begin
                max_d = max_q;
            end
        end else begin
            stat_d.valid = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q  <= '0;
            id_q     <= '0;
            stat_q   <= '0;
            reads_q  <= '0;
            writes_q <= '0;
            max_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            id_q     <= id_d;
            stat_q   <= stat_d;
            reads_q  <= reads_d;
            writes_q <= writes_d;
            max_q    <= max_d;
            err_q    <= err_d;
        end
    end

    assign global_cycle    = cycle_q;
    assign stat_valid      = stat_q.valid;
    assign stat_request_id = stat_q.request_id;
    assign stat_addr       = stat_q.addr;
    assign stat_rd_en      = stat_q.rd_en;
    assign stat_wr_en      = stat_q.wr_en;
    assign stat_cycle      = stat_q.cycle;
    assign stat_latency    = stat_q.latency;
    assign total_reads     = reads_q;
    assign total_writes    = writes_q;
    assign max_latency     = max_q;
    assign err_underflow   = err_q;

endmodule
